// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous byte-wide SRAM.
// Every output, SRAM strobes included, comes straight from a flop to keep strobes glitch-free.
module sram_arbiter #(
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [17:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [17:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        ext_RAMCS_b,
    output logic        ext_RAMOE_b,
    output logic        ext_RAMWE_b,
    output logic [17:0] ext_RAMA,
    output logic [7:0]  ext_RAMDin,
    input  logic [7:0]  ext_RAMDout
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD,
        DONE
    } state_t;

    localparam logic [3:0] WE_RELOAD = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_RELOAD = 4'(RD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_b_q, sel_b_d;        // port owning the current access
    logic        last_b_q, last_b_d;      // port granted most recently
    logic [17:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [7:0]  a_rdata_q, a_rdata_d;
    logic [7:0]  b_rdata_q, b_rdata_d;

    logic        grant_b;

    // A contested grant goes to whichever port was not served last.
    assign grant_b = b_req && (!a_req || !last_b_q);

    // State register plus all output flops.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sel_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            addr_q    <= 18'd0;
            din_q     <= 8'd0;
            cs_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_b_q   <= sel_b_d;
            last_b_q  <= last_b_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            cs_q      <= cs_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Next-state logic; the counter is reloaded whenever a timed state is entered.
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_b_d  = sel_b_q;
        last_b_d = last_b_q;
        addr_d   = addr_q;
        din_d    = din_q;
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_b_d  = grant_b;
                    last_b_d = grant_b;
                    addr_d   = grant_b ? b_addr  : a_addr;
                    din_d    = grant_b ? b_wdata : a_wdata;
                    if (grant_b ? b_we : a_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_RELOAD;
                    end
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WE_RELOAD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: state_d = DONE;
            RD: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so the flops line up with it.
    always_comb begin
        cs_d      = !(state_d inside {WR_SETUP, WR_PULSE, WR_HOLD, RD});
        oe_d      = (state_d != RD);
        we_d      = (state_d != WR_PULSE);
        a_ack_d   = (state_d == DONE) && !sel_b_d;
        b_ack_d   = (state_d == DONE) && sel_b_d;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (state_q == RD && state_d == DONE) begin
            if (sel_b_q) b_rdata_d = ext_RAMDout;
            else         a_rdata_d = ext_RAMDout;
        end
    end

    assign ext_RAMCS_b = cs_q;
    assign ext_RAMOE_b = oe_q;
    assign ext_RAMWE_b = we_q;
    assign ext_RAMA    = addr_q;
    assign ext_RAMDin  = din_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;

endmodule
